uart_rx_arbiter: RTL

- Merges the byte streams of up to 2**channel_bits UART receivers into one AXI-stream byte channel.
- Each output byte is tagged with its source channel index.
- Sits between a bank of receivers, each with a tvalid/tready/tdata byte output and a one-cycle overflow pulse, and a single downstream consumer such as a host FIFO or register interface.
- Arbitration is round-robin. The block also keeps a sticky, software-clearable overflow flag per channel.

---
 rtl/uart_rx_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/uart_rx_arbiter.sv
// Round-robin merge of N UART receiver byte streams into one tagged AXI-stream
// byte channel, with a sticky, software-clearable overflow flag per channel.
module uart_rx_arbiter #(
  parameter int channel_bits = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(1<<channel_bits)-1:0]   in_tvalid,
  output logic [(1<<channel_bits)-1:0]   in_tready,
  input  logic [8*(1<<channel_bits)-1:0] in_tdata,
  input  logic [(1<<channel_bits)-1:0]   in_overflow,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic [7:0]                    out_tdata,
  output logic [channel_bits-1:0]       out_tid,
  output logic [(1<<channel_bits)-1:0]   overflow_flags,
  input  logic [(1<<channel_bits)-1:0]   overflow_clear
);

  localparam int N = 1 << channel_bits;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              out_tdata_q, out_tdata_d;
  logic [channel_bits-1:0] out_tid_q, out_tid_d;
  logic [channel_bits-1:0] last_grant_q, last_grant_d;
  logic [N-1:0]            overflow_flags_q, overflow_flags_d;

  logic                    can_accept;
  logic                    grant_vld;
  logic [channel_bits-1:0] grant_idx;
  logic [channel_bits-1:0] search_idx;
  logic                    transfer;

  // Search starts one past the last granted channel; the index wraps modulo N.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    search_idx = '0;
    for (int k = 1; k <= N; k++) begin
      search_idx = last_grant_q + channel_bits'(k);
      if (!grant_vld && in_tvalid[search_idx]) begin
        grant_vld = 1'b1;
        grant_idx = search_idx;
      end
    end
  end

  assign can_accept = (state_q == EMPTY) || out_tready;
  assign transfer   = can_accept && grant_vld && !rst;
  assign in_tready  = transfer ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

  always_comb begin
    state_d          = state_q;
    out_tdata_d      = out_tdata_q;
    out_tid_d        = out_tid_q;
    last_grant_d     = last_grant_q;
    if (transfer) begin
      state_d      = FULL;
      out_tdata_d  = in_tdata[8*grant_idx +: 8];
      out_tid_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (state_q == FULL && out_tready) begin
      state_d = EMPTY;
    end
    // A set pulse overrides a clear strobe arriving in the same cycle.
    overflow_flags_d = (overflow_flags_q & ~overflow_clear) | in_overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= EMPTY;
      out_tdata_q      <= '0;
      out_tid_q        <= '0;
      last_grant_q     <= channel_bits'(N - 1);
      overflow_flags_q <= '0;
    end else begin
      state_q          <= state_d;
      out_tdata_q      <= out_tdata_d;
      out_tid_q        <= out_tid_d;
      last_grant_q     <= last_grant_d;
      overflow_flags_q <= overflow_flags_d;
    end
  end

  assign out_tvalid     = (state_q == FULL);
  assign out_tdata      = out_tdata_q;
  assign out_tid        = out_tid_q;
  assign overflow_flags = overflow_flags_q;

endmodule
